// File: rtl/commit_eng_if.sv
// Manage-engine to commit-engine link: message metadata plus payload flit stream.
// The manage engine drives through the master modport; the commit engine uses the slave modport.
interface commit_eng_if #(
   parameter int unsigned NOC_DATA_W     = 512,
   parameter int unsigned NOC_PADBYTES   = NOC_DATA_W / 8,
   parameter int unsigned NOC_PADBYTES_W = $clog2(NOC_PADBYTES)
);
   typedef struct packed {
      logic [31:0] src_ip;
      logic [31:0] dst_ip;
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [15:0] data_length;
   } udp_info;

   logic                      manage_commit_msg_val;
   udp_info                   manage_commit_pkt_info;
   logic                      commit_manage_msg_rdy;

   logic                      manage_commit_req_val;
   logic [NOC_DATA_W-1:0]     manage_commit_req;
   logic                      manage_commit_req_last;
   logic [NOC_PADBYTES_W-1:0] manage_commit_req_padbytes;
   logic                      commit_manage_req_rdy;

   modport master (
      output manage_commit_msg_val, manage_commit_pkt_info,
      input  commit_manage_msg_rdy,
      output manage_commit_req_val, manage_commit_req, manage_commit_req_last,
      output manage_commit_req_padbytes,
      input  commit_manage_req_rdy
   );

   modport slave (
      input  manage_commit_msg_val, manage_commit_pkt_info,
      output commit_manage_msg_rdy,
      input  manage_commit_req_val, manage_commit_req, manage_commit_req_last,
      input  manage_commit_req_padbytes,
      output commit_manage_req_rdy
   );
endinterface

// File: rtl/commit_eng.sv
// Commit message engine: pulls view/opnum from the first payload flit, validates them
// against replica state and issues a single commit-update request per accepted message.
module commit_eng #(
   parameter int unsigned NOC_DATA_W     = 512,
   parameter int unsigned NOC_PADBYTES   = NOC_DATA_W / 8,
   parameter int unsigned NOC_PADBYTES_W = $clog2(NOC_PADBYTES)
) (
   input  logic        clk,
   input  logic        rst,
   commit_eng_if.slave mgr,
   input  logic [63:0] curr_view,
   input  logic [63:0] curr_commit_opnum,
   output logic        commit_update_val,
   output logic [63:0] commit_update_opnum,
   input  logic        commit_update_rdy,
   output logic        commit_eng_rdy,
   output logic [31:0] commit_drop_cnt,
   output logic [31:0] commit_apply_cnt
);
   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DRAIN,
      CHECK,
      UPDATE
   } state_t;

   state_t      state;
   logic [15:0] data_length;
   logic [63:0] view_num;
   logic [63:0] commit_opnum;
   logic        short_msg;

   logic        msg_rdy;
   logic        req_rdy;
   logic        flit_fire;
   logic        apply;

   assign mgr.commit_manage_msg_rdy = msg_rdy;
   assign mgr.commit_manage_req_rdy = req_rdy;

   assign flit_fire = mgr.manage_commit_req_val & req_rdy;
   assign apply     = !short_msg && (view_num == curr_view) &&
                      (commit_opnum > curr_commit_opnum);

   // Only the leading 16 payload bytes and data_length carry meaning here.
   logic unused_bits;
   assign unused_bits = ^{mgr.manage_commit_req[NOC_DATA_W-129:0],
                          mgr.manage_commit_req_padbytes,
                          mgr.manage_commit_pkt_info.src_ip,
                          mgr.manage_commit_pkt_info.dst_ip,
                          mgr.manage_commit_pkt_info.src_port,
                          mgr.manage_commit_pkt_info.dst_port};

   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= IDLE;
         msg_rdy             <= 1'b1;
         req_rdy             <= 1'b0;
         commit_update_val   <= 1'b0;
         commit_eng_rdy      <= 1'b1;
         commit_drop_cnt     <= '0;
         commit_apply_cnt    <= '0;
         commit_update_opnum <= '0;
         data_length         <= '0;
         view_num            <= '0;
         commit_opnum        <= '0;
         short_msg           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mgr.manage_commit_msg_val) begin
                  data_length    <= mgr.manage_commit_pkt_info.data_length;
                  state          <= HDR;
                  msg_rdy        <= 1'b0;
                  req_rdy        <= 1'b1;
                  commit_eng_rdy <= 1'b0;
               end
            end
            HDR: begin
               if (flit_fire) begin
                  view_num     <= mgr.manage_commit_req[NOC_DATA_W-1 -: 64];
                  commit_opnum <= mgr.manage_commit_req[NOC_DATA_W-65 -: 64];
                  short_msg    <= (data_length < 16'd16);
                  if (mgr.manage_commit_req_last) begin
                     state   <= CHECK;
                     req_rdy <= 1'b0;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (flit_fire && mgr.manage_commit_req_last) begin
                  state   <= CHECK;
                  req_rdy <= 1'b0;
               end
            end
            CHECK: begin
               if (apply) begin
                  state               <= UPDATE;
                  commit_update_val   <= 1'b1;
                  commit_update_opnum <= commit_opnum;
               end else begin
                  state           <= IDLE;
                  commit_drop_cnt <= commit_drop_cnt + 32'd1;
                  msg_rdy         <= 1'b1;
                  commit_eng_rdy  <= 1'b1;
               end
            end
            UPDATE: begin
               if (commit_update_rdy) begin
                  state             <= IDLE;
                  commit_update_val <= 1'b0;
                  commit_apply_cnt  <= commit_apply_cnt + 32'd1;
                  msg_rdy           <= 1'b1;
                  commit_eng_rdy    <= 1'b1;
               end
            end
            default: begin
               state             <= IDLE;
               msg_rdy           <= 1'b1;
               req_rdy           <= 1'b0;
               commit_update_val <= 1'b0;
               commit_eng_rdy    <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_commit_eng.sv
// Directed bench for commit_eng: apply/drop decisions, draining, back-pressure and reset.
module tb_commit_eng;
   localparam int unsigned W = 512;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] curr_view;
   logic [63:0] curr_commit_opnum;
   logic        commit_update_val;
   logic [63:0] commit_update_opnum;
   logic        commit_update_rdy;
   logic        commit_eng_rdy;
   logic [31:0] commit_drop_cnt;
   logic [31:0] commit_apply_cnt;

   int vectors = 0;
   int miscompares = 0;

   commit_eng_if #(.NOC_DATA_W(W)) bus ();

   commit_eng #(.NOC_DATA_W(W)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .mgr                 (bus),
      .curr_view           (curr_view),
      .curr_commit_opnum   (curr_commit_opnum),
      .commit_update_val   (commit_update_val),
      .commit_update_opnum (commit_update_opnum),
      .commit_update_rdy   (commit_update_rdy),
      .commit_eng_rdy      (commit_eng_rdy),
      .commit_drop_cnt     (commit_drop_cnt),
      .commit_apply_cnt    (commit_apply_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_meta(input logic [15:0] len);
      int n = 0;
      bus.manage_commit_pkt_info             = '0;
      bus.manage_commit_pkt_info.data_length = len;
      bus.manage_commit_msg_val              = 1'b1;
      while (!bus.commit_manage_msg_rdy && n < 50) begin
         tick();
         n++;
      end
      vectors++;
      if (bus.commit_manage_msg_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL meta_timeout: msg_rdy=%b required 1 within 50 cycles", bus.commit_manage_msg_rdy);
      end
      tick();
      bus.manage_commit_msg_val = 1'b0;
   endtask

   task automatic send_flit(input logic [63:0] view, input logic [63:0] opnum, input logic last);
      logic [W-1:0] f;
      int n = 0;
      f = '0;
      f[W-1 -: 64]  = view;
      f[W-65 -: 64] = opnum;
      bus.manage_commit_req      = f;
      bus.manage_commit_req_last = last;
      bus.manage_commit_req_val  = 1'b1;
      while (!bus.commit_manage_req_rdy && n < 50) begin
         tick();
         n++;
      end
      vectors++;
      if (bus.commit_manage_req_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL flit_timeout: req_rdy=%b required 1 within 50 cycles", bus.commit_manage_req_rdy);
      end
      tick();
      bus.manage_commit_req_val  = 1'b0;
      bus.manage_commit_req_last = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      vectors++;
      if ({bus.commit_manage_msg_rdy, bus.commit_manage_req_rdy, commit_update_val, commit_eng_rdy} !== 4'b1001) begin
         miscompares++;
         $display("FAIL reset_flags: msg/req/upd/eng=%b required 1001",
                  {bus.commit_manage_msg_rdy, bus.commit_manage_req_rdy, commit_update_val, commit_eng_rdy});
      end
      vectors++;
      if (commit_drop_cnt !== 32'd0 || commit_apply_cnt !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_cnts: drop=%0d apply=%0d required 0 0", commit_drop_cnt, commit_apply_cnt);
      end
   endtask

   task automatic test_apply();
      curr_view = 64'd5; curr_commit_opnum = 64'd7; commit_update_rdy = 1'b1;
      send_meta(16'd16);
      send_flit(64'd5, 64'd10, 1'b1);
      vectors++;
      if (commit_update_val !== 1'b0 || commit_eng_rdy !== 1'b0) begin
         miscompares++;
         $display("FAIL apply_check_cycle: upd_val=%b eng_rdy=%b required 0 0", commit_update_val, commit_eng_rdy);
      end
      tick();
      vectors++;
      if (commit_update_val !== 1'b1 || commit_update_opnum !== 64'd10) begin
         miscompares++;
         $display("FAIL apply_update: val=%b opnum=%0d required 1 10", commit_update_val, commit_update_opnum);
      end
      tick();
      vectors++;
      if (commit_update_val !== 1'b0 || commit_eng_rdy !== 1'b1 || commit_apply_cnt !== 32'd1) begin
         miscompares++;
         $display("FAIL apply_retire: val=%b eng_rdy=%b apply=%0d required 0 1 1",
                  commit_update_val, commit_eng_rdy, commit_apply_cnt);
      end
   endtask

   task automatic test_drop_view();
      curr_view = 64'd6; curr_commit_opnum = 64'd7;
      send_meta(16'd16);
      send_flit(64'd5, 64'd10, 1'b1);
      tick();
      vectors++;
      if (commit_update_val !== 1'b0 || commit_drop_cnt !== 32'd1 || commit_eng_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL drop_view: val=%b drop=%0d eng_rdy=%b required 0 1 1",
                  commit_update_val, commit_drop_cnt, commit_eng_rdy);
      end
   endtask

   task automatic test_drop_stale();
      curr_view = 64'd5; curr_commit_opnum = 64'd7;
      send_meta(16'd16);
      send_flit(64'd5, 64'd7, 1'b1);
      tick();
      vectors++;
      if (commit_update_val !== 1'b0 || commit_drop_cnt !== 32'd2 || commit_apply_cnt !== 32'd1) begin
         miscompares++;
         $display("FAIL drop_stale: val=%b drop=%0d apply=%0d required 0 2 1",
                  commit_update_val, commit_drop_cnt, commit_apply_cnt);
      end
   endtask

   task automatic test_multi_flit();
      curr_view = 64'd5; curr_commit_opnum = 64'd10;
      send_meta(16'd150);
      send_flit(64'd5, 64'd20, 1'b0);
      vectors++;
      if (commit_update_val !== 1'b0 || bus.commit_manage_req_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL multi_drain: val=%b req_rdy=%b required 0 1", commit_update_val, bus.commit_manage_req_rdy);
      end
      send_flit(64'd99, 64'd99, 1'b0);
      vectors++;
      if (commit_update_val !== 1'b0 || commit_eng_rdy !== 1'b0) begin
         miscompares++;
         $display("FAIL multi_mid: val=%b eng_rdy=%b required 0 0", commit_update_val, commit_eng_rdy);
      end
      send_flit(64'd98, 64'd98, 1'b1);
      tick();
      vectors++;
      if (commit_update_val !== 1'b1 || commit_update_opnum !== 64'd20) begin
         miscompares++;
         $display("FAIL multi_update: val=%b opnum=%0d required 1 20", commit_update_val, commit_update_opnum);
      end
      tick();
      vectors++;
      if (commit_apply_cnt !== 32'd2 || commit_eng_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL multi_retire: apply=%0d eng_rdy=%b required 2 1", commit_apply_cnt, commit_eng_rdy);
      end
   endtask

   task automatic test_backpressure();
      curr_view = 64'd5; curr_commit_opnum = 64'd10; commit_update_rdy = 1'b0;
      send_meta(16'd16);
      send_flit(64'd5, 64'd30, 1'b1);
      tick();
      // A second message is offered and the replica view moves while the update waits.
      bus.manage_commit_pkt_info             = '0;
      bus.manage_commit_pkt_info.data_length = 16'd16;
      bus.manage_commit_msg_val              = 1'b1;
      curr_view = 64'd9;
      for (int i = 0; i < 10; i++) begin
         vectors++;
         if (commit_update_val !== 1'b1 || commit_update_opnum !== 64'd30 || bus.commit_manage_msg_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: val=%b opnum=%0d msg_rdy=%b required 1 30 0",
                     i, commit_update_val, commit_update_opnum, bus.commit_manage_msg_rdy);
         end
         tick();
      end
      commit_update_rdy = 1'b1;
      tick();
      vectors++;
      if (bus.commit_manage_msg_rdy !== 1'b1 || commit_apply_cnt !== 32'd3 || commit_update_val !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_release: msg_rdy=%b apply=%0d val=%b required 1 3 0",
                  bus.commit_manage_msg_rdy, commit_apply_cnt, commit_update_val);
      end
      tick();
      bus.manage_commit_msg_val = 1'b0;
      vectors++;
      if (bus.commit_manage_msg_rdy !== 1'b0 || bus.commit_manage_req_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_second_meta: msg_rdy=%b req_rdy=%b required 0 1",
                  bus.commit_manage_msg_rdy, bus.commit_manage_req_rdy);
      end
      send_flit(64'd9, 64'd31, 1'b1);
      tick();
      tick();
      vectors++;
      if (commit_apply_cnt !== 32'd4) begin
         miscompares++;
         $display("FAIL bp_second_apply: apply=%0d required 4", commit_apply_cnt);
      end
   endtask

   task automatic test_payload_before_meta();
      logic [W-1:0] f;
      curr_view = 64'd9; curr_commit_opnum = 64'd31;
      f = '0;
      f[W-1 -: 64]  = 64'd9;
      f[W-65 -: 64] = 64'd50;
      bus.manage_commit_req      = f;
      bus.manage_commit_req_last = 1'b1;
      bus.manage_commit_req_val  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (bus.commit_manage_req_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL early_payload[%0d]: req_rdy=%b required 0", i, bus.commit_manage_req_rdy);
         end
         tick();
      end
      send_meta(16'd16);
      vectors++;
      if (bus.commit_manage_req_rdy !== 1'b1) begin
         miscompares++;
         $display("FAIL early_after_meta: req_rdy=%b required 1", bus.commit_manage_req_rdy);
      end
      tick();
      bus.manage_commit_req_val  = 1'b0;
      bus.manage_commit_req_last = 1'b0;
      tick();
      vectors++;
      if (commit_update_val !== 1'b1 || commit_update_opnum !== 64'd50) begin
         miscompares++;
         $display("FAIL early_update: val=%b opnum=%0d required 1 50", commit_update_val, commit_update_opnum);
      end
      tick();
      vectors++;
      if (commit_apply_cnt !== 32'd5) begin
         miscompares++;
         $display("FAIL early_apply: apply=%0d required 5", commit_apply_cnt);
      end
   endtask

   task automatic test_short();
      curr_view = 64'd9; curr_commit_opnum = 64'd50;
      send_meta(16'd8);
      send_flit(64'd9, 64'd60, 1'b1);
      tick();
      vectors++;
      if (commit_update_val !== 1'b0 || commit_drop_cnt !== 32'd3 || commit_apply_cnt !== 32'd5) begin
         miscompares++;
         $display("FAIL short_drop: val=%b drop=%0d apply=%0d required 0 3 5",
                  commit_update_val, commit_drop_cnt, commit_apply_cnt);
      end
   endtask

   task automatic test_reset_mid_drain();
      curr_view = 64'd9; curr_commit_opnum = 64'd50;
      send_meta(16'd150);
      send_flit(64'd9, 64'd70, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if ({bus.commit_manage_msg_rdy, bus.commit_manage_req_rdy, commit_update_val, commit_eng_rdy} !== 4'b1001) begin
         miscompares++;
         $display("FAIL rst_drain_flags: msg/req/upd/eng=%b required 1001",
                  {bus.commit_manage_msg_rdy, bus.commit_manage_req_rdy, commit_update_val, commit_eng_rdy});
      end
      vectors++;
      if (commit_drop_cnt !== 32'd0 || commit_apply_cnt !== 32'd0) begin
         miscompares++;
         $display("FAIL rst_drain_cnts: drop=%0d apply=%0d required 0 0", commit_drop_cnt, commit_apply_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if (commit_update_val !== 1'b0 || commit_eng_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_drain_idle[%0d]: val=%b eng_rdy=%b required 0 1", i, commit_update_val, commit_eng_rdy);
         end
      end
   endtask

   initial begin
      rst                            = 1'b1;
      curr_view                      = '0;
      curr_commit_opnum              = '0;
      commit_update_rdy              = 1'b1;
      bus.manage_commit_msg_val      = 1'b0;
      bus.manage_commit_pkt_info     = '0;
      bus.manage_commit_req_val      = 1'b0;
      bus.manage_commit_req          = '0;
      bus.manage_commit_req_last     = 1'b0;
      bus.manage_commit_req_padbytes = '0;
      #2;
      test_reset();
      test_apply();
      test_drop_view();
      test_drop_stale();
      test_multi_flit();
      test_backpressure();
      test_payload_before_meta();
      test_short();
      test_reset_mid_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
